// File: rtl/adc_if.sv
// Serial-to-parallel receiver for the codec/ADC stream: MSB-first words framed by
// L_start/R_start strobes, presented as signed LEFT/RIGHT samples with valid pulses.
//
// state | meaning
// IDLE  | waiting for a strobe, SDATA ignored
// SHIFT | capturing a word, one bit per SCLK rising edge
module adc_if #(
    parameter int WIDTH = 16
) (
    input  logic             SCLK,
    input  logic             reset,
    input  logic             L_start,
    input  logic             R_start,
    input  logic             SDATA,
    output logic [WIDTH-1:0] L_data,
    output logic [WIDTH-1:0] R_data,
    output logic             L_valid,
    output logic             R_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             chan;

    logic             strobe;
    logic             new_chan;
    logic [WIDTH-1:0] word;
    logic             lsb_edge;

    // LEFT wins when both strobes arrive together, matching the transmitter.
    assign strobe   = L_start | R_start;
    assign new_chan = L_start ? CH_LEFT : CH_RIGHT;
    assign word     = {shreg[WIDTH-2:0], SDATA};
    assign lsb_edge = (state == SHIFT) && (cnt == CNT_LAST);

    always_ff @(posedge SCLK) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            chan      <= CH_LEFT;
            L_data    <= '0;
            R_data    <= '0;
            L_valid   <= 1'b0;
            R_valid   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            L_valid   <= 1'b0;
            R_valid   <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (strobe) begin
                        chan  <= new_chan;
                        cnt   <= '0;
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (lsb_edge) begin
                        shreg <= word;
                        if (chan == CH_LEFT) begin
                            L_data  <= word;
                            L_valid <= 1'b1;
                        end else begin
                            R_data  <= word;
                            R_valid <= 1'b1;
                        end
                        // A strobe on the LSB edge chains straight into the next frame.
                        if (strobe) begin
                            chan  <= new_chan;
                            cnt   <= '0;
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (strobe) begin
                        frame_err <= 1'b1;
                        chan      <= new_chan;
                        cnt       <= '0;
                        state     <= SHIFT;
                        busy      <= 1'b1;
                    end else begin
                        shreg <= word;
                        cnt   <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/adc_if.md
Name: adc_if

Overview:
- Serial-to-parallel receiver for the audio codec/ADC data stream.
- Mirror of the DAC serializer: it uses the same SCLK, the same L_start/R_start framing strobes and MSB-first 16-bit words.
- It captures the serial input SDATA and presents completed LEFT/RIGHT signed samples with one-cycle valid strobes to the audio datapath.
- It also flags framing errors, i.e. a strobe that arrives before a word is complete.

Parameters:
- WIDTH, 16: sample width in bits, shifted MSB first. Legal range 2..32.

Ports:
- SCLK  input  1  serial clock (1.56 MHz). All logic is on its rising edge; the transmitter drives on the falling edge.
- reset  input  1  synchronous, active-high reset.
- L_start  input  1  strobe marking the start of a LEFT word.
- R_start  input  1  strobe marking the start of a RIGHT word.
- SDATA  input  1  serial data from the ADC, MSB first.
- L_data  output  WIDTH  last completed LEFT sample (signed).
- R_data  output  WIDTH  last completed RIGHT sample (signed).
- L_valid  output  1  one-cycle pulse when L_data updates.
- R_valid  output  1  one-cycle pulse when R_data updates.
- busy  output  1  high while a word is being shifted in.
- frame_err  output  1  one-cycle pulse when a word is aborted by an early strobe.

Behaviour:
- Clock and reset:
  - Single clock SCLK, rising edge only. reset is synchronous, active-high.
  - Reset values: state=IDLE, L_data=0, R_data=0, L_valid=0, R_valid=0, busy=0, frame_err=0, shift register=0, bit counter=0, channel flag=LEFT.
  - reset asserted mid-word discards the partial word, with no valid and no frame_err pulse.
- Strobe priority: a strobe is "seen" on a rising edge where L_start=1 or R_start=1. If both are high, LEFT wins, matching the transmitter's priority.
- States:
  - IDLE: SDATA is ignored.
  - SHIFT: a word is being captured.
- Start edge: on the edge where a strobe is seen, latch the channel flag, clear the bit counter, go to SHIFT and set busy=1 after that edge. SDATA on this edge is NOT sampled.
- SHIFT edges:
  - On each of the next WIDTH edges: shreg <= {shreg[WIDTH-2:0], SDATA}; cnt <= cnt+1.
  - The MSB is sampled on edge start+1 and the LSB on edge start+WIDTH.
- LSB edge (cnt==WIDTH-1):
  - The word {shreg[WIDTH-2:0], SDATA} is written to L_data or R_data according to the channel flag.
  - The matching valid pulses high for exactly the following cycle.
  - State returns to IDLE and busy=0, unless a strobe is seen on the same edge (see below).
- Latency: a valid pulse appears 1 cycle after the LSB is sampled, i.e. WIDTH+1 edges after the start edge.
- Data holding: L_data and R_data hold their value until the next completed word of the same channel. A partial word never alters them.
- Strobe during SHIFT with cnt < WIDTH-1:
  - The partial word is discarded and frame_err pulses for 1 cycle.
  - A new frame starts on that edge for the new channel; SDATA on that edge is not sampled.
- Strobe on the LSB edge:
  - The current word completes normally (valid pulse, no frame_err).
  - The new frame begins on the same edge and busy stays 1.
- After the LSB with no strobe: remain in IDLE. Any number of idle edges are allowed; extra SDATA bits are ignored.
- Valid pulses are never asserted for more than one consecutive cycle without a new complete word.
- Arithmetic: no sign extension or truncation. Output bit WIDTH-1 is the first received bit.

Test Plan:
- Reset then single LEFT word:
  - Stimulus: reset 2 cycles; L_start 1 cycle; shift 0x8001 MSB first.
  - Required: L_data=0x8001 and L_valid=1 exactly 17 edges after the strobe edge; R_data stays 0; busy falls with valid.
- Back-to-back L/R frames using the DAC framing:
  - Stimulus: L_start, 16 bits of 0x1234, R_start on the LSB edge, 16 bits of 0xFEDC.
  - Required: L_valid then R_valid, L_data=0x1234, R_data=0xFEDC; busy never drops; no frame_err.
- Early strobe:
  - Stimulus: L_start, 7 bits, then R_start, then 16 bits of 0x00FF.
  - Required: frame_err pulses 1 cycle at the R_start edge; L_valid never fires and L_data is unchanged; R_data=0x00FF.
- Simultaneous strobes:
  - Stimulus: L_start=R_start=1, then 0xAAAA.
  - Required: L_data=0xAAAA with L_valid; R_valid stays 0.
- Reset mid-word:
  - Stimulus: assert reset after 10 bits of 0x5555 following a prior completed L_data=0x1111.
  - Required: all outputs return to 0; no valid or frame_err pulse; the next full word is captured correctly.
- Idle gap:
  - Stimulus: after a completed word, 40 edges of random SDATA with no strobe.
  - Required: no valid pulses; outputs unchanged; busy=0.
